cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, physical address width.
REQ-002 SHALL have parameter LINE_W, default 256, cache line width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports i_address input ADDR_W, i_read input 1, i_rdata output LINE_W and i_resp output 1: the I-cache line-read channel.
REQ-006 SHALL have ports d_address input ADDR_W, d_read input 1, d_write input 1, d_wdata input LINE_W, d_rdata output LINE_W and d_resp output 1: the D-cache line read/write channel.
REQ-007 SHALL have ports pmem_address output ADDR_W, pmem_read output 1, pmem_write output 1, pmem_wdata output LINE_W, pmem_rdata input LINE_W and pmem_resp input 1: the shared physical-memory channel.
REQ-008 SHALL have port busy  output 1  high whenever a transaction is granted and not yet completed.

Function
REQ-009 SHALL implement FSM states IDLE, I_BUSY, D_BUSY and DONE.
REQ-010 In IDLE, SHALL grant at most one requester per cycle; a request is i_read for I, or d_read|d_write for D.
REQ-011 On simultaneous I and D requests in IDLE, SHALL grant the requester not served by the previous grant (round-robin via 1-bit last_grant register).
REQ-012 On grant, SHALL latch address, operation and d_wdata into internal registers; pmem_* outputs SHALL drive only from these registers while busy.
REQ-013 SHALL assert pmem_read/pmem_write from the cycle after grant and hold them until the cycle pmem_resp is sampled high.
REQ-014 If d_read and d_write are both high at grant, SHALL perform a write.
REQ-015 In I_BUSY or D_BUSY with pmem_resp=1, SHALL pulse the granted requester's resp combinationally in that same cycle, with rdata=pmem_rdata.
REQ-016 In that same cycle, SHALL deassert pmem_read/pmem_write (combinational gate on pmem_resp) and move to DONE.
REQ-017 The non-granted requester's resp SHALL stay 0 and its rdata SHALL hold its last value.
REQ-018 DONE SHALL last exactly one cycle with no pmem access and no grant, so that requesters can drop request lines; it then returns to IDLE.
REQ-019 Total latency SHALL be grant cycle + pmem latency + 1 DONE cycle; back-to-back same-requester accesses SHALL have a minimum spacing of 3 cycles.
REQ-020 A request dropped while busy SHALL NOT abort the transaction; completion still pulses resp once.
REQ-021 pmem_resp arriving in IDLE or DONE SHALL be ignored.
REQ-022 A request arriving while busy SHALL wait, with no loss or reordering.
REQ-023 Under continuous dual requests, grants SHALL strictly alternate I, D, I, D.
REQ-024 busy SHALL be 1 in I_BUSY and D_BUSY, and 0 otherwise.

Reset
REQ-025 On rst=1, SHALL immediately and asynchronously force state=IDLE, pmem_read=0, pmem_write=0, i_resp=0, d_resp=0, busy=0 and last_grant=D (so I wins the first tie).
REQ-026 On rst=1, latched address/data and i_rdata/d_rdata SHALL reset to 0.
REQ-027 Reset mid-transaction SHALL abandon the transaction with no resp pulse; the first grant after rst falls SHALL follow REQ-011 from the reset state.

Verification
REQ-028 Single I read: i_read=1, i_address=32'h40008000, memory returns 256'h1234 after 10 cycles -> pmem_read=1, pmem_address=32'h40008000; i_resp is a 1-cycle pulse with i_rdata=256'h1234; d_resp stays 0.
REQ-029 Single D write: d_write=1, d_address=32'h00000060, d_wdata=256'hABCD -> pmem_write=1 with pmem_wdata=256'hABCD until pmem_resp; d_resp pulses once; pmem_read stays 0.
REQ-030 Tie after reset: i_read and d_read asserted in the same cycle -> I granted first; D granted 1 cycle after DONE; D's pmem_address is unchanged by I's address.
REQ-031 Sustained contention: both requesters re-request immediately after each resp for 8 transactions -> grant order I, D, I, D, I, D, I, D; exactly 4 i_resp and 4 d_resp pulses.
REQ-032 Reset mid-access: rst pulsed 3 cycles into a D read -> pmem_read falls within the reset cycle; no d_resp; later pmem_resp is ignored; a subsequent I read completes normally.
REQ-033 Stray response: pmem_resp pulsed while in IDLE -> no resp on either channel and no state change.

Source files
------------

// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter
// Shares one physical-memory channel between an I-cache (line reads only)
// and a D-cache (line reads and writes). One transaction is in flight at a
// time. Simultaneous requests are settled round-robin, so I wins the first
// tie after reset. After each completion a one-cycle DONE gap gives the
// requesters time to drop their request lines before the next grant.
//
// Ports
//   clk, rst        : single clock; asynchronous active-high reset
//   i_address/i_read/i_rdata/i_resp
//                   : I-cache line-read channel
//   d_address/d_read/d_write/d_wdata/d_rdata/d_resp
//                   : D-cache line read/write channel
//   pmem_address/pmem_read/pmem_write/pmem_wdata/pmem_rdata/pmem_resp
//                   : shared physical-memory channel
//   busy            : a granted transaction has not yet completed
// ---------------------------------------------------------------------------
module cache_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_address,
   input  logic              i_read,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic [ADDR_W-1:0] d_address,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic [ADDR_W-1:0] pmem_address,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic GRANT_I = 1'b0;
   localparam logic GRANT_D = 1'b1;

   state_t            state_r;
   state_t            next_state_s;
   logic              last_grant_r;
   logic [ADDR_W-1:0] addr_r;
   logic              write_r;
   logic [LINE_W-1:0] wdata_r;
   logic [LINE_W-1:0] i_rdata_r;
   logic [LINE_W-1:0] d_rdata_r;
   logic              i_req_s;
   logic              d_req_s;
   logic              grant_i_s;
   logic              grant_d_s;

   assign i_req_s = i_read;
   assign d_req_s = d_read | d_write;

   // Next-state logic and the single-cycle grant decision made in IDLE.
   always_comb begin
      next_state_s = state_r;
      grant_i_s    = 1'b0;
      grant_d_s    = 1'b0;
      case (state_r)
         IDLE: begin
            // I wins unless D also requests and I was the one served last.
            if (i_req_s && (!d_req_s || (last_grant_r == GRANT_D))) begin
               grant_i_s    = 1'b1;
               next_state_s = I_BUSY;
            end else if (d_req_s) begin
               grant_d_s    = 1'b1;
               next_state_s = D_BUSY;
            end else begin
               next_state_s = IDLE;
            end
         end
         I_BUSY, D_BUSY: begin
            if (pmem_resp) begin
               next_state_s = DONE;
            end else begin
               next_state_s = state_r;
            end
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Round-robin pointer; reset to D so that I wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_r <= GRANT_D;
      end else if (grant_i_s) begin
         last_grant_r <= GRANT_I;
      end else if (grant_d_s) begin
         last_grant_r <= GRANT_D;
      end
   end

   // Transaction registers captured at grant; memory is driven only from here,
   // so requesters may change or drop their inputs once granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_r  <= {ADDR_W{1'b0}};
         write_r <= 1'b0;
         wdata_r <= {LINE_W{1'b0}};
      end else if (grant_i_s) begin
         addr_r  <= i_address;
         write_r <= 1'b0;
         wdata_r <= d_wdata;
      end else if (grant_d_s) begin
         addr_r  <= d_address;
         write_r <= d_write;     // read+write together resolves to a write
         wdata_r <= d_wdata;
      end
   end

   // Per-channel read data held between completions.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_rdata_r <= {LINE_W{1'b0}};
         d_rdata_r <= {LINE_W{1'b0}};
      end else begin
         if (i_resp) begin
            i_rdata_r <= pmem_rdata;
         end
         if (d_resp) begin
            d_rdata_r <= pmem_rdata;
         end
      end
   end

   // Channel outputs; the memory strobe is gated off in the response cycle
   // and the response is forwarded in that same cycle.
   always_comb begin
      busy       = 1'b0;
      i_resp     = 1'b0;
      d_resp     = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      case (state_r)
         I_BUSY: begin
            busy      = 1'b1;
            i_resp    = pmem_resp;
            pmem_read = !pmem_resp;
         end
         D_BUSY: begin
            busy       = 1'b1;
            d_resp     = pmem_resp;
            pmem_read  = !write_r && !pmem_resp;
            pmem_write = write_r && !pmem_resp;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
      if (i_resp) begin
         i_rdata = pmem_rdata;
      end else begin
         i_rdata = i_rdata_r;
      end
      if (d_resp) begin
         d_rdata = pmem_rdata;
      end else begin
         d_rdata = d_rdata_r;
      end
   end

   assign pmem_address = addr_r;
   assign pmem_wdata   = wdata_r;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: a transaction-level reference model plus a
// behavioural memory that answers after a configurable number of cycles.
// Inputs change 4 ns after a rising edge; outputs are sampled there too.
module tb_cache_arbiter;
   localparam logic [31:0] IA = 32'h1000_0000;
   localparam logic [31:0] DA = 32'h2000_0040;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [31:0]  i_address, d_address, pmem_address;
   logic         i_read, i_resp, d_read, d_write, d_resp;
   logic         pmem_read, pmem_write, pmem_resp, busy;
   logic [255:0] i_rdata, d_rdata, d_wdata, pmem_wdata, pmem_rdata;

   always #5 clk = ~clk;

   cache_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
      .clk(clk), .rst(rst),
      .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .busy(busy)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;

   // reference model: owner 0 = none, 1 = I, 2 = D
   int           m_owner, m_last;
   bit           m_done, m_write;
   logic [31:0]  m_addr;
   logic [255:0] m_wdata, exp_i_rdata, exp_d_rdata;
   logic [255:0] ref_mem [logic [31:0]];

   // behavioural memory
   logic [255:0] pm_mem [logic [31:0]];
   bit           mem_busy, mem_wr, stray_req, stray_en, rand_lat;
   int           mem_cnt;
   int           lat = 2;
   logic [31:0]  mem_addr;
   logic [255:0] mem_wdata;

   // observation counters
   int n_iresp, n_dresp, n_pread, n_pwrite;
   int resp_log[$];
   int i_resp_cyc, last_grant_cyc;
   bit prev_busy;

   function automatic logic [255:0] init_line(input logic [31:0] a);
      return {4{a, ~a}};
   endfunction

   function automatic logic [255:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_line(a);
   endfunction

   function automatic logic [255:0] pm_rd(input logic [31:0] a);
      if (pm_mem.exists(a)) return pm_mem[a];
      return init_line(a);
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chka(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chkw(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out waiting for completion (cycle %0d)", name, cyc);
   endtask

   task automatic model_reset();
      m_owner = 0; m_done = 1'b0; m_last = 2; m_addr = 32'd0; m_write = 1'b0;
      m_wdata = 256'd0; exp_i_rdata = 256'd0; exp_d_rdata = 256'd0;
   endtask

   // What the arbiter must do at the coming edge, from the inputs present now.
   task automatic model_edge();
      bit ir, dr;
      if (rst) return;
      ir = i_read;
      dr = d_read | d_write;
      if (m_owner != 0 && pmem_resp) begin
         m_owner = 0;
         m_done  = 1'b1;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_owner == 0) begin
         if (ir && (!dr || m_last == 2)) begin
            m_owner = 1; m_last = 1; m_addr = i_address; m_write = 1'b0;
         end else if (dr) begin
            m_owner = 2; m_last = 2; m_addr = d_address; m_write = d_write;
            m_wdata = d_wdata;
         end
      end
   endtask

   // Memory side, driven 1 ns after the edge.
   task automatic respond();
      pmem_resp  = 1'b0;
      pmem_rdata = {8{$urandom}};
      if (stray_en && m_owner == 0 && !mem_busy && $urandom_range(0, 15) == 0)
         stray_req = 1'b1;
      if (stray_req) begin
         pmem_resp = 1'b1;
         stray_req = 1'b0;
      end else if (mem_busy) begin
         mem_cnt++;
         if (mem_cnt >= lat) begin
            pmem_resp  = 1'b1;
            pmem_rdata = pm_rd(mem_addr);
            if (mem_wr) pm_mem[mem_addr] = mem_wdata;
            mem_busy = 1'b0;
         end
      end
   endtask

   task automatic check_cycle();
      bit e_busy, e_pr, e_pw, e_ir, e_dr;
      e_busy = (m_owner != 0);
      e_ir   = (m_owner == 1) && pmem_resp;
      e_dr   = (m_owner == 2) && pmem_resp;
      e_pr   = ((m_owner == 1) || (m_owner == 2 && !m_write)) && !pmem_resp;
      e_pw   = (m_owner == 2) && m_write && !pmem_resp;
      if (e_ir) exp_i_rdata = ref_rd(m_addr);
      if (e_dr) begin
         exp_d_rdata = ref_rd(m_addr);
         if (m_write) ref_mem[m_addr] = m_wdata;
      end
      chk1("busy", busy, e_busy);
      chk1("pmem_read", pmem_read, e_pr);
      chk1("pmem_write", pmem_write, e_pw);
      chk1("i_resp", i_resp, e_ir);
      chk1("d_resp", d_resp, e_dr);
      chkw("i_rdata", i_rdata, exp_i_rdata);
      chkw("d_rdata", d_rdata, exp_d_rdata);
      if (e_busy) chka("pmem_address", pmem_address, m_addr);
      if (e_pw) chkw("pmem_wdata", pmem_wdata, m_wdata);
      if (i_resp) begin n_iresp++; resp_log.push_back(1); i_resp_cyc = cyc; end
      if (d_resp) begin n_dresp++; resp_log.push_back(2); end
      if (pmem_read) n_pread++;
      if (pmem_write) n_pwrite++;
      if (busy && !prev_busy) last_grant_cyc = cyc;
      prev_busy = busy;
      if (!mem_busy && !pmem_resp && (pmem_read || pmem_write)) begin
         mem_busy = 1'b1; mem_cnt = 0; mem_addr = pmem_address;
         mem_wr = pmem_write; mem_wdata = pmem_wdata;
         if (rand_lat) lat = $urandom_range(1, 4);
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      cyc++;
      #1 respond();
      #3 check_cycle();
   endtask

   task automatic do_reset(input bit clear_mem);
      rst = 1'b1;
      #1;
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_pmem_read", pmem_read, 1'b0);
      chk1("rst_pmem_write", pmem_write, 1'b0);
      chk1("rst_i_resp", i_resp, 1'b0);
      chk1("rst_d_resp", d_resp, 1'b0);
      chka("rst_pmem_address", pmem_address, 32'd0);
      chkw("rst_i_rdata", i_rdata, 256'd0);
      chkw("rst_d_rdata", d_rdata, 256'd0);
      model_reset();
      if (clear_mem) begin mem_busy = 1'b0; stray_req = 1'b0; end
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic finish_txn(input string name, input int budget);
      int n = 0;
      while ((m_owner != 0 || m_done) && n < budget) begin step(); n++; end
      if (m_owner != 0 || m_done) timeout_fail(name);
   endtask

   typedef struct {
      bit          do_rst;
      bit          ir, dr, dw;
      bit          e_busy, e_pr, e_pw;
      logic [31:0] e_addr;
   } vec_t;

   vec_t vt[8];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ni0, nd0, np0, nw0, n;
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      i_address = 32'd0; d_address = 32'd0; d_wdata = 256'd0;
      pmem_resp = 1'b0; pmem_rdata = 256'd0;
      stray_en = 1'b0; stray_req = 1'b0; rand_lat = 1'b0; prev_busy = 1'b0;
      model_reset();
      #2;
      do_reset(1'b1);

      // grant decisions out of IDLE, first busy cycle
      vt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, IA};  // I alone
      vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, DA};  // D read
      vt[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, DA};  // D write
      vt[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, DA};  // D rd+wr -> write
      vt[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, IA};  // tie after reset -> I
      vt[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, DA};  // tie, I served last -> D
      vt[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, IA};  // tie, D served last -> I
      vt[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IA};  // nothing
      lat = 2;
      for (int k = 0; k < 8; k++) begin
         if (vt[k].do_rst) do_reset(1'b1);
         i_read = vt[k].ir; i_address = IA;
         d_read = vt[k].dr; d_write = vt[k].dw; d_address = DA;
         d_wdata = 256'hfeed_0000 + 256'(k);
         step();
         chk1($sformatf("vec%0d_busy", k), busy, vt[k].e_busy);
         chk1($sformatf("vec%0d_pmem_read", k), pmem_read, vt[k].e_pr);
         chk1($sformatf("vec%0d_pmem_write", k), pmem_write, vt[k].e_pw);
         if (vt[k].e_busy) chka($sformatf("vec%0d_addr", k), pmem_address, vt[k].e_addr);
         i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
         finish_txn($sformatf("vec%0d_done", k), 40);
      end

      // single I read, memory answers after 10 cycles
      do_reset(1'b1);
      lat = 10;
      ref_mem[32'h4000_8000] = 256'h1234;
      pm_mem[32'h4000_8000]  = 256'h1234;
      ni0 = n_iresp; nd0 = n_dresp; np0 = n_pread;
      i_read = 1'b1; i_address = 32'h4000_8000;
      step();
      i_read = 1'b0;
      finish_txn("iread_done", 40);
      chki("iread_resp_count", n_iresp - ni0, 1);
      chki("iread_d_resp_count", n_dresp - nd0, 0);
      chkw("iread_rdata", i_rdata, 256'h1234);
      chki("iread_pmem_read_cycles", n_pread - np0, 10);
      chka("iread_mem_addr", mem_addr, 32'h4000_8000);

      // single D write
      lat = 3;
      ni0 = n_iresp; nd0 = n_dresp; np0 = n_pread; nw0 = n_pwrite;
      d_write = 1'b1; d_address = 32'h0000_0060; d_wdata = 256'hABCD;
      step();
      d_write = 1'b0;
      finish_txn("dwrite_done", 40);
      chki("dwrite_resp_count", n_dresp - nd0, 1);
      chki("dwrite_i_resp_count", n_iresp - ni0, 0);
      chki("dwrite_pmem_read_cycles", n_pread - np0, 0);
      chki("dwrite_pmem_write_cycles", n_pwrite - nw0, 3);
      chkw("dwrite_mem_data", pm_rd(32'h0000_0060), 256'hABCD);

      // tie right after reset: I first, D granted right after DONE
      do_reset(1'b1);
      lat = 2;
      resp_log.delete();
      i_read = 1'b1; i_address = IA; d_read = 1'b1; d_address = DA;
      n = 0;
      while (resp_log.size() < 2 && n < 60) begin
         step();
         n++;
         if (i_resp) i_read = 1'b0;
         if (d_resp) d_read = 1'b0;
      end
      i_read = 1'b0; d_read = 1'b0;
      chki("tie_resp_count", resp_log.size(), 2);
      if (resp_log.size() >= 2) begin
         chki("tie_first", resp_log[0], 1);
         chki("tie_second", resp_log[1], 2);
      end
      chki("tie_d_grant_spacing", last_grant_cyc - i_resp_cyc, 3);
      finish_txn("tie_done", 40);

      // sustained contention: eight transactions alternate I, D, ...
      do_reset(1'b1);
      lat = 1;
      resp_log.delete();
      ni0 = n_iresp; nd0 = n_dresp;
      i_read = 1'b1; d_read = 1'b1;
      n = 0;
      while (resp_log.size() < 8 && n < 200) begin step(); n++; end
      i_read = 1'b0; d_read = 1'b0;
      finish_txn("contend_done", 40);
      chki("contend_resp_count", resp_log.size(), 8);
      for (int k = 0; k < resp_log.size(); k++)
         chki($sformatf("contend_order%0d", k), resp_log[k], (k % 2 == 0) ? 1 : 2);
      chki("contend_i_resps", n_iresp - ni0, 4);
      chki("contend_d_resps", n_dresp - nd0, 4);

      // reset three cycles into a D read; the late memory answer is ignored
      do_reset(1'b1);
      lat = 10;
      nd0 = n_dresp;
      d_read = 1'b1; d_address = 32'h0000_0100;
      step();
      step();
      step();
      chk1("midrst_pmem_read_before", pmem_read, 1'b1);
      d_read = 1'b0;
      do_reset(1'b0);
      repeat (12) step();
      chki("midrst_no_d_resp", n_dresp - nd0, 0);
      chk1("midrst_idle", busy, 1'b0);
      ni0 = n_iresp;
      i_read = 1'b1; i_address = 32'h4000_0200;
      step();
      i_read = 1'b0;
      finish_txn("midrst_iread_done", 40);
      chki("midrst_iread_resp", n_iresp - ni0, 1);

      // stray response in IDLE
      ni0 = n_iresp; nd0 = n_dresp;
      stray_req = 1'b1;
      step();
      chk1("stray_pmem_resp_seen", pmem_resp, 1'b1);
      step();
      chk1("stray_still_idle", busy, 1'b0);
      chki("stray_no_i_resp", n_iresp - ni0, 0);
      chki("stray_no_d_resp", n_dresp - nd0, 0);

      // randomized traffic against the model
      do_reset(1'b1);
      rand_lat = 1'b1;
      stray_en = 1'b1;
      for (int c = 0; c < 600; c++) begin
         step();
         if (i_read && i_resp) i_read = 1'b0;
         else if (!i_read && $urandom_range(0, 2) == 0) begin
            i_read = 1'b1;
            i_address = 32'h1000_0000 + 32'($urandom_range(0, 7) * 32);
         end else if (i_read && $urandom_range(0, 39) == 0) i_read = 1'b0;
         if ((d_read || d_write) && d_resp) begin
            d_read = 1'b0; d_write = 1'b0;
         end else if (!(d_read || d_write) && $urandom_range(0, 2) == 0) begin
            d_read    = 1'($urandom_range(0, 1));
            d_write   = !d_read || ($urandom_range(0, 3) == 0);
            d_address = 32'h1000_0000 + 32'($urandom_range(0, 7) * 32);
            d_wdata   = {8{$urandom}};
         end else if ((d_read || d_write) && $urandom_range(0, 39) == 0) begin
            d_read = 1'b0; d_write = 1'b0;
         end
      end
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      stray_en = 1'b0;
      finish_txn("random_done", 40);
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
